// File: rtl/quant_pkg.sv
// Shared defaults, derived latency and tag type for the quantizer wrapper
// around the pipelined long-division divider.
package quant_pkg;

    localparam int DEF_CW    = 12;
    localparam int DEF_QW    = 8;
    localparam int DEF_STEPS = 12;
    localparam int DEF_DIV_W = 22;

    // in_valid to out_valid
    localparam int LAT = DEF_STEPS + 2;

    localparam int ERR_QT   = 0;
    localparam int ERR_BLK  = 1;
    localparam int ERR_SYNC = 2;

    localparam logic [5:0] IDX_LAST = 6'd63;

    typedef struct packed {
        logic       sign;
        logic [5:0] idx;
    } qtag_t;

endpackage

// File: rtl/quant_tag_delay.sv
// Fixed-depth valid+tag shift register that advances every cycle; DEPTH must be >= 2.
module quant_tag_delay #(
    parameter int DEPTH = 13,
    parameter int TW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [TW-1:0] out_tag,
    output logic          pend_valid
);

    logic [DEPTH-1:0] vld_r;
    logic [TW-1:0]    tag_r [DEPTH];

    // Shift valid and tag one stage per clock; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            vld_r    <= {vld_r[DEPTH-2:0], in_valid};
            tag_r[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign out_valid  = vld_r[DEPTH-1];
    assign out_tag    = tag_r[DEPTH-1];
    // valids that will still be inside the line after the next shift
    assign pend_valid = |vld_r[DEPTH-2:0];

endmodule

// File: rtl/quant_div_wrap.sv
// Quantizer wrapper: issues rounding-prescaled divisions to an external pipelined
// divider and re-signs the returned quotients using a latency-matched tag line.
module quant_div_wrap
    import quant_pkg::*;
#(
    parameter int CW    = DEF_CW,
    parameter int QW    = DEF_QW,
    parameter int STEPS = DEF_STEPS,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sob,
    input  logic [CW-1:0]    in_coef,
    input  logic             qt_we,
    input  logic [5:0]       qt_addr,
    input  logic [QW-1:0]    qt_data,
    output logic [DIV_W-1:0] div_dividend,
    output logic [DIV_W-1:0] div_divisor,
    output logic             div_din_valid,
    input  logic [STEPS-1:0] div_quotient,
    input  logic             div_dout_valid,
    output logic             out_valid,
    output logic [CW-1:0]    out_coef,
    output logic [5:0]       out_idx,
    output logic             out_last,
    output logic             busy,
    output logic [2:0]       err
);

    logic [QW-1:0] qt_mem_r [64];
    logic [5:0]    cnt_r;
    logic          wrap_r;

    logic [5:0]    idx_s;
    logic [QW-1:0] q_s;
    logic [CW-2:0] mag_s;
    qtag_t         tag_in_s;
    qtag_t         tag_head_s;
    logic [$bits(qtag_t)-1:0] tag_head_raw_s;
    logic          head_valid_s;
    logic          pend_valid_s;
    logic          qt_acc_s;
    logic          blk_bad_s;
    logic [CW-2:0] q_trunc_s;
    logic [CW-1:0] coef_s;
    logic          unused_quot_hi_s;

    function automatic logic [CW-2:0] sat_mag(input logic [CW-1:0] c);
        logic [CW-1:0] neg;
        neg = -c;
        if (!c[CW-1]) begin
            return c[CW-2:0];
        end else if (neg[CW-1]) begin
            // most negative value negates to itself
            return {(CW-1){1'b1}};
        end else begin
            return neg[CW-2:0];
        end
    endfunction

    // Issue-side decode: index, step lookup with zero guard, magnitude, error qualifiers.
    always_comb begin
        idx_s = in_sob ? 6'd0 : cnt_r;
        if (qt_mem_r[idx_s] == '0) begin
            q_s = {{(QW-1){1'b0}}, 1'b1};
        end else begin
            q_s = qt_mem_r[idx_s];
        end
        mag_s         = sat_mag(in_coef);
        tag_in_s.sign = in_coef[CW-1];
        tag_in_s.idx  = idx_s;
        qt_acc_s      = qt_we && !busy && !in_valid;
        blk_bad_s     = in_valid && (in_sob ? (cnt_r != 6'd0) : wrap_r);
    end

    // Issue stage: one division request per valid coefficient.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= 6'd0;
            wrap_r        <= 1'b0;
            div_din_valid <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
        end else begin
            div_din_valid <= in_valid;
            if (in_valid) begin
                cnt_r        <= idx_s + 6'd1;
                wrap_r       <= (idx_s == IDX_LAST);
                div_dividend <= {{(DIV_W-CW){1'b0}}, mag_s, 1'b0} + {{(DIV_W-QW){1'b0}}, q_s};
                div_divisor  <= {{(DIV_W-QW-STEPS){1'b0}}, q_s, {STEPS{1'b0}}};
            end
        end
    end

    // Quant table write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && qt_acc_s) begin
            qt_mem_r[qt_addr] <= qt_data;
        end
    end

    quant_tag_delay #(
        .DEPTH (STEPS + 1),
        .TW    ($bits(qtag_t))
    ) u_tag_dly (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_tag     (tag_in_s),
        .out_valid  (head_valid_s),
        .out_tag    (tag_head_raw_s),
        .pend_valid (pend_valid_s)
    );

    assign tag_head_s       = qtag_t'(tag_head_raw_s);
    assign unused_quot_hi_s = ^div_quotient[STEPS-1:CW-1];

    // Re-apply sign to the returned magnitude without producing negative zero.
    always_comb begin
        q_trunc_s = div_quotient[CW-2:0];
        if (tag_head_s.sign && (q_trunc_s != '0)) begin
            coef_s = -{1'b0, q_trunc_s};
        end else begin
            coef_s = {1'b0, q_trunc_s};
        end
    end

    // Recombine stage, busy tracking and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_idx   <= 6'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            err       <= 3'b000;
        end else begin
            out_valid <= div_dout_valid;
            busy      <= in_valid | pend_valid_s;
            if (div_dout_valid) begin
                out_coef <= coef_s;
                out_idx  <= tag_head_s.idx;
                out_last <= (tag_head_s.idx == IDX_LAST);
            end
            if (div_dout_valid != head_valid_s) begin
                err[ERR_SYNC] <= 1'b1;
            end
            if (blk_bad_s) begin
                err[ERR_BLK] <= 1'b1;
            end
            if (qt_we && !qt_acc_s) begin
                err[ERR_QT] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quant_div_wrap.sv
// Bench for quant_div_wrap: vector table, two streamed blocks, error and reset cases;
// the external divider is modelled as an STEPS-deep pipeline built from quant_tag_delay.
`timescale 1ns/1ps
module tb_quant_div_wrap;
    import quant_pkg::*;

    localparam int CW    = DEF_CW;
    localparam int QW    = DEF_QW;
    localparam int STEPS = DEF_STEPS;
    localparam int DIV_W = DEF_DIV_W;
    localparam int NV    = 14;

    typedef struct {
        logic [QW-1:0]        q;
        logic signed [CW-1:0] coef;
        logic signed [CW-1:0] exp;
    } vec_t;

    typedef struct {
        logic signed [CW-1:0] coef;
        logic [5:0]           idx;
        logic                 last;
        int                   cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_sob;
    logic [CW-1:0]    in_coef;
    logic             qt_we;
    logic [5:0]       qt_addr;
    logic [QW-1:0]    qt_data;
    logic [DIV_W-1:0] div_dividend;
    logic [DIV_W-1:0] div_divisor;
    logic             div_din_valid;
    logic [STEPS-1:0] div_quotient;
    logic             div_dout_valid;
    logic             out_valid;
    logic [CW-1:0]    out_coef;
    logic [5:0]       out_idx;
    logic             out_last;
    logic             busy;
    logic [2:0]       err;

    logic [DIV_W-1:0] dq_s;
    logic [DIV_W-1:0] quo_full_s;
    logic [STEPS-1:0] mdl_quot_in;
    logic [STEPS-1:0] mdl_q;
    logic             mdl_v;
    logic             unused_mdl_pend;
    logic             inj_v;
    logic [STEPS-1:0] inj_q;

    vec_t          vecs [NV];
    logic [QW-1:0] bqt [64];
    logic [5:0]    bidx;
    exp_t          sb [$];
    exp_t          mon_e;
    exp_t          spur_e;
    int            cyc = 0;
    int            chk_cnt = 0;
    int            fail_cnt = 0;

    quant_div_wrap dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_sob         (in_sob),
        .in_coef        (in_coef),
        .qt_we          (qt_we),
        .qt_addr        (qt_addr),
        .qt_data        (qt_data),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_din_valid  (div_din_valid),
        .div_quotient   (div_quotient),
        .div_dout_valid (div_dout_valid),
        .out_valid      (out_valid),
        .out_coef       (out_coef),
        .out_idx        (out_idx),
        .out_last       (out_last),
        .busy           (busy),
        .err            (err)
    );

    // divider model: floor(dividend / (2*Q)) with Q = divisor >> STEPS, STEPS cycles deep
    always_comb begin
        dq_s       = div_divisor >> STEPS;
        quo_full_s = (dq_s == '0) ? '0 : div_dividend / (dq_s << 1);
    end
    assign mdl_quot_in = quo_full_s[STEPS-1:0];

    quant_tag_delay #(
        .DEPTH (STEPS),
        .TW    (STEPS)
    ) u_div_mdl (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (div_din_valid),
        .in_tag     (mdl_quot_in),
        .out_valid  (mdl_v),
        .out_tag    (mdl_q),
        .pend_valid (unused_mdl_pend)
    );

    assign div_dout_valid = mdl_v | inj_v;
    assign div_quotient   = inj_v ? inj_q : mdl_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic signed [CW-1:0] ref_q(input logic signed [CW-1:0] c, input logic [QW-1:0] q);
        int qq, mag, r, rem;
        qq  = (q == '0) ? 1 : int'(q);
        mag = (c < 0) ? -int'(c) : int'(c);
        if (mag > (1 << (CW-1)) - 1) mag = (1 << (CW-1)) - 1;
        r   = mag / qq;
        rem = mag - r * qq;
        if (2 * rem >= qq) r = r + 1;
        if (c < 0) r = -r;
        return CW'(r);
    endfunction

    task automatic check(input string name, input int got, input int req);
        chk_cnt++;
        if (got !== req) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic issue(input logic signed [CW-1:0] c, input logic sob,
                         input logic use_exp, input logic signed [CW-1:0] xc);
        exp_t       e;
        logic [5:0] idx;
        idx    = sob ? 6'd0 : bidx;
        e.coef = use_exp ? xc : ref_q(c, bqt[idx]);
        e.idx  = idx;
        e.last = (idx == 6'd63);
        e.cyc  = cyc + LAT;
        sb.push_back(e);
        bidx     = idx + 6'd1;
        in_valid = 1'b1;
        in_sob   = sob;
        in_coef  = c;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n        = 0;
        in_valid = 1'b0;
        in_sob   = 1'b0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, int'(sb.size()), 0);
        check({name, "_busy"}, int'(busy), 0);
        @(negedge clk);
    endtask

    // scoreboard: every out_valid must match the oldest expectation, at its cycle
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            chk_cnt++;
            if (sb.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_out: got coef=%0d idx=%0d, required no output",
                         $signed(out_coef), out_idx);
            end else begin
                mon_e = sb.pop_front();
                if ($signed(out_coef) !== mon_e.coef || out_idx !== mon_e.idx ||
                    out_last !== mon_e.last || cyc != mon_e.cyc) begin
                    fail_cnt++;
                    $display("FAIL out_sample: got coef=%0d idx=%0d last=%0b cyc=%0d, required coef=%0d idx=%0d last=%0b cyc=%0d",
                             $signed(out_coef), out_idx, out_last, cyc,
                             mon_e.coef, mon_e.idx, mon_e.last, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sob = 1'b0; in_coef = '0;
        qt_we = 1'b0; qt_addr = 6'd0; qt_data = '0;
        inj_v = 1'b0; inj_q = '0; bidx = 6'd0;

        vecs[0]  = '{8'd16,  12'sd40,   12'sd3};
        vecs[1]  = '{8'd10,  -12'sd24,  -12'sd2};
        vecs[2]  = '{8'd10,  -12'sd4,   12'sd0};
        vecs[3]  = '{8'd0,   12'h800,   -12'sd2047};
        vecs[4]  = '{8'd16,  -12'sd40,  -12'sd3};
        vecs[5]  = '{8'd16,  12'sd8,    12'sd1};
        vecs[6]  = '{8'd16,  12'sd7,    12'sd0};
        vecs[7]  = '{8'd255, 12'sd2047, 12'sd8};
        vecs[8]  = '{8'd1,   12'sd2047, 12'sd2047};
        vecs[9]  = '{8'd1,   -12'sd2047, -12'sd2047};
        vecs[10] = '{8'd3,   -12'sd1,   12'sd0};
        vecs[11] = '{8'd3,   12'sd0,    12'sd0};
        vecs[12] = '{8'd7,   -12'sd11,  -12'sd2};
        vecs[13] = '{8'd0,   12'sd5,    12'sd5};

        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_coef", int'(out_coef), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_din_valid", int'(div_din_valid), 0);
        check("rst_dividend", int'(div_dividend), 0);
        check("rst_divisor", int'(div_divisor), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            bqt[i]  = (i < NV) ? vecs[i].q : QW'($urandom_range(255));
            qt_we   = 1'b1;
            qt_addr = 6'(i);
            qt_data = bqt[i];
            @(negedge clk);
        end
        qt_we = 1'b0;
        check("err_after_load", int'(err), 0);

        // two back-to-back blocks: vector table first, then model-checked random data
        for (int k = 0; k < 128; k++) begin
            if (k < NV) issue(vecs[k].coef, 1'b1 && (k == 0), 1'b1, vecs[k].exp);
            else        issue(CW'($urandom_range(4095)), (k == 64), 1'b0, '0);
        end
        wait_idle("blocks");
        check("blocks_err", int'(err), 0);

        // in_sob at counter 5, then a table write while busy
        issue(12'sd40, 1'b1, 1'b1, 12'sd3);
        for (int k = 1; k < 5; k++) issue(CW'(k * 37), 1'b0, 1'b0, '0);
        issue(12'sd40, 1'b1, 1'b1, 12'sd3);
        in_valid = 1'b0; in_sob = 1'b0;
        qt_we = 1'b1; qt_addr = 6'd0; qt_data = 8'd99;
        @(negedge clk);
        qt_we = 1'b0;
        wait_idle("blk");
        check("err_blk_qt", int'(err), 3);
        issue(-12'sd40, 1'b1, 1'b1, -12'sd3);
        wait_idle("qt_unchanged");

        // reset in the middle of a burst
        for (int k = 0; k < 4; k++) issue(CW'(100 + k), (k == 0), 1'b0, '0);
        in_valid = 1'b0; in_sob = 1'b0; in_coef = '0;
        rst = 1'b1;
        sb.delete();
        bidx = 6'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("midrst_err", int'(err), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(out_valid), 0);

        // spurious divider output while nothing is in flight
        spur_e.coef = 12'sd5;
        spur_e.idx  = 6'd0;
        spur_e.last = 1'b0;
        spur_e.cyc  = cyc + 1;
        sb.push_back(spur_e);
        inj_q = 12'd5;
        inj_v = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        @(negedge clk);
        check("sync_err", int'(err), 4);
        wait_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/quant_div_wrap.md
Name: quant_div_wrap

Overview:
- Quantizer front/back end around the team's pipelined long-division divider.
- Upstream:
  - takes signed DCT coefficients in 8x8-block order.
  - looks up the quantization step per coefficient index.
  - forms a rounding-prescaled dividend/divisor pair and issues one division per cycle.
- Downstream:
  - keeps sign and index in a delay line matched to divider latency.
  - re-applies the sign to the returned quotient.
  - emits the signed quantized coefficient to the zig-zag/entropy stage.

Parameters:
- CW, 12, coefficient width (signed two's complement).
- QW, 8, quant table entry width (unsigned).
- STEPS, 12, divider pipeline depth and quotient width; must be >= CW.
- DIV_W, 22, divider operand width; must be >= QW+STEPS+2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  coefficient valid.
- in_sob  in  1  first coefficient of a block (with in_valid).
- in_coef  in  CW  signed DCT coefficient.
- qt_we  in  1  quant table write strobe.
- qt_addr  in  6  table index.
- qt_data  in  QW  table value.
- div_dividend  out  DIV_W  to divider.
- div_divisor  out  DIV_W  to divider.
- div_din_valid  out  1  to divider.
- div_quotient  in  STEPS  from divider.
- div_dout_valid  in  1  from divider.
- out_valid  out  1  result valid.
- out_coef  out  CW  signed quantized coefficient.
- out_idx  out  6  coefficient index 0..63.
- out_last  out  1  index 63.
- busy  out  1  any entry in flight.
- err  out  3  sticky {sync_err, blk_err, qt_err}.

Behaviour:
- Reset (sync, active-high):
  - index counter = 0, delay line cleared, table contents retained.
  - all outputs 0 (div_dividend, div_divisor, div_din_valid, out_*, busy, err).
  - Reset mid-operation drops everything in flight; the external divider is reset with the same rst.
- Issue stage (registered, 1 cycle):
  - On in_valid: idx = in_sob ? 0 : counter; counter <= idx+1 (wraps 63->0).
  - mag = |in_coef|; -2^(CW-1) saturates to 2^(CW-1)-1.
  - Q = table[idx]; Q==0 is treated as 1.
  - div_dividend = 2*mag + Q (zero-extended).
  - div_divisor = Q << STEPS.
  - Divider then yields floor((2*mag+Q)/(2Q)) = round-half-away(|x|/Q).
  - Precondition dividend < 2*divisor holds for all legal inputs.
  - div_din_valid = in_valid, registered.
- Delay line:
  - STEPS+1 deep shift register of {valid, sign, idx}.
  - Advances every cycle; no backpressure anywhere.
- Recombine stage (registered, 1 cycle):
  - On div_dout_valid: q = div_quotient truncated to CW-1 bits.
  - out_coef = (sign && q!=0) ? -q : q.
  - out_idx = delayed idx; out_last = (idx==63); out_valid = 1.
- Latency: in_valid to out_valid = STEPS+2 cycles. Throughput 1 per cycle, back-to-back.
- sync_err: set when div_dout_valid != delay-line head valid. The output is still produced from div_quotient.
- blk_err: set when in_sob is asserted with counter != 0, or counter wraps 63->0 and the next in_valid has in_sob=0. Index still restarts per in_sob.
- qt_err / table writes:
  - Table writes are accepted only when busy==0 and in_valid==0.
  - Otherwise the write is ignored and qt_err is set.
  - An accepted write affects coefficients issued from the next cycle.
- busy = in_valid registered OR any delay-line valid.
- err bits clear only on rst.

Decomposition:
- Package quant_pkg:
  - CW, QW, STEPS, DIV_W defaults.
  - derived LAT = STEPS+2.
  - typedef qtag_t {logic sign; logic [5:0] idx;}.
  - err bit position constants.
- Sub-module quant_tag_delay: parameterised-depth valid+tag shift register. The testbench also reuses it as a latency model.
- Quant table: a 64xQW register array inside the top level.

Test Plan:
- Table all 16, in_coef = 40 at idx 0 -> out_coef 3 (40/16=2.5 rounds away) at cycle STEPS+2, out_idx 0.
- Table[1]=10, in_coef = -24 -> out_coef -2; in_coef = -4 -> out_coef 0 (no negative zero).
- Table[0]=0, in_coef = -2048 -> treated as Q=1, saturated to 2047 -> out_coef -2047.
- 64 back-to-back coefficients with in_sob on the first, then a second block -> 128 consecutive out_valid, out_last on idx 63 and 127th sample, blk_err 0.
- Assert in_sob at counter 5 -> blk_err set, out_idx restarts at 0. qt_we while busy -> qt_err set, table unchanged.
- Reset at cycle 4 of an in-flight burst -> no out_valid afterwards, err 0, busy 0. Inject a spurious div_dout_valid -> sync_err set.
